spi_tx_sched: RTL

Drain scheduler between the byte FIFO (`ufifo`) and the SPI transmit shifter. Pops bytes from the FIFO and presents them to the shifter over a valid/ready handshake. Groups consecutive bytes into chip-select-framed bursts of at most `BURST_MAX` bytes, with a guaranteed chip-select-high gap between bursts. It is the only reader of the FIFO.

---
 rtl/spi_tx_sched.sv | 131 +++++++++++++
 1 files changed

// File: rtl/spi_tx_sched.sv
// spi_tx_sched: drains the byte FIFO into the SPI transmit shifter.
// Bytes are grouped into chip-select-framed bursts of at most BURST_MAX
// bytes, and every burst is followed by an IDLE_GAP-cycle chip-select-high gap.
//
// Handshake: a byte moves to the shifter on every rising edge where
// o_tx_valid && i_tx_ready. While o_tx_valid is high and i_tx_ready is low,
// o_tx_data is held stable. o_tx_valid drops only after a handshake, or on reset.
module spi_tx_sched #(
    parameter int LGFLEN    = 2,
    parameter int BURST_MAX = 4,
    parameter int IDLE_GAP  = 2
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_enable,
    input  logic                             i_fifo_empty,
    input  logic [LGFLEN:0]                  i_fifo_used,
    input  logic [7:0]                       i_fifo_data,
    output logic                             o_fifo_rd,
    output logic                             o_tx_valid,
    output logic [7:0]                       o_tx_data,
    input  logic                             i_tx_ready,
    output logic                             o_cs_n,
    output logic                             o_busy,
    output logic [$clog2(BURST_MAX+1)-1:0]   o_burst_cnt
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [CNT_W-1:0] BURST_MAX_C = CNT_W'(BURST_MAX);
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(IDLE_GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             cs_n_q, cs_n_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    logic slot_free;
    logic pop;

    // Occupancy is informational only; scheduling relies on the empty flag.
    logic fifo_used_unused;
    assign fifo_used_unused = ^i_fifo_used;

    // The output slot can take a new byte when it is empty or being handed off now.
    assign slot_free = !tx_valid_q || i_tx_ready;
    assign pop = (state_q == ST_XFER) && slot_free && !i_fifo_empty && i_enable
                 && (burst_cnt_q < BURST_MAX_C);

    // Next-state and datapath decisions for the burst sequencer.
    always_comb begin
        state_d     = state_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        burst_cnt_d = burst_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                burst_cnt_d = '0;
                if (i_enable && !i_fifo_empty) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // Chip select is already low; gives the slave one cycle of setup.
                state_d = ST_XFER;
            end
            ST_XFER: begin
                if (pop) begin
                    tx_data_d   = i_fifo_data;
                    tx_valid_d  = 1'b1;
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end else if (slot_free) begin
                    // Pending byte (if any) has completed and nothing follows it.
                    tx_valid_d  = 1'b0;
                    state_d     = ST_GAP;
                    burst_cnt_d = '0;
                    gap_cnt_d   = '0;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Chip select is registered and follows the state being entered.
        cs_n_d = !((state_d == ST_SETUP) || (state_d == ST_XFER));
    end

    // State and output registers; reset discards any byte held in the slot.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            cs_n_q      <= 1'b1;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            burst_cnt_q <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cs_n_q      <= cs_n_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            burst_cnt_q <= burst_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign o_fifo_rd   = pop;
    assign o_tx_valid  = tx_valid_q;
    assign o_tx_data   = tx_data_q;
    assign o_cs_n      = cs_n_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_burst_cnt = burst_cnt_q;

endmodule
